// File: rtl/logistic_iter_if.sv
// Bundle of the logistic_iter data/handshake signals.
// master: upstream selector / bench side (drives mu and calc_clock).
// slave: logistic_iter side (drives the iteration results).
interface logistic_iter_if #(
    parameter int CNT_W = 16
) ();
    logic [17:0]      mu;
    logic             calc_clock;
    logic [17:0]      x;
    logic             x_valid;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             overrun;

    modport master (
        output mu,
        output calc_clock,
        input  x,
        input  x_valid,
        input  iter_cnt,
        input  busy,
        input  overrun
    );

    modport slave (
        input  mu,
        input  calc_clock,
        output x,
        output x_valid,
        output iter_cnt,
        output busy,
        output overrun
    );
endinterface

// File: rtl/logistic_iter.sv
// Logistic map iterator: x(n+1) = mu * x(n) * (1 - x(n)), Q2.16 unsigned.
// One iteration per synchronized rising edge of calc_clock.
// A change of mu restarts the orbit from X0. The first BURN_IN iterations
// after a restart are not flagged with x_valid.
// One 18x18 multiplier is shared between the two product steps.
module logistic_iter #(
    parameter logic [17:0] X0      = 18'h04CCD,
    parameter int          BURN_IN = 64,
    parameter int          CNT_W   = 16
) (
    input  logic            CLK,
    input  logic            RST,
    logistic_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL1 = 2'd1,
        S_MUL2 = 2'd2
    } state_t;

    localparam logic [17:0]      ONE       = 18'h10000;
    localparam logic [CNT_W-1:0] BURN_LIM  = CNT_W'(BURN_IN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Synchronizer: [0],[1] are the two metastability stages, [2] is the
    // edge register used to detect the 0->1 transition.
    logic [2:0]       sync_q, sync_d;
    logic             tick_q, tick_d;

    state_t           state_q, state_d;
    logic [17:0]      mu_reg_q, mu_reg_d;
    logic [17:0]      x_q, x_d;
    logic [17:0]      p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_valid_q, x_valid_d;
    logic             overrun_q, overrun_d;

    // Shared multiplier operands and result
    logic [17:0]      om;
    logic [17:0]      mul_a, mul_b;
    logic [35:0]      prod;
    logic [17:0]      prod_mid;
    logic [CNT_W-1:0] cnt_inc;

    // Synchronizer next values and registered tick for each 0->1 transition
    always_comb begin
        sync_d = {sync_q[1], sync_q[0], bus.calc_clock};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    // Operand select for the single multiplier: x*(1-x) in MUL1, mu*p in MUL2
    always_comb begin
        om    = ONE - x_q;
        mul_a = x_q;
        mul_b = om;
        if (state_q == S_MUL2) begin
            mul_a = mu_reg_q;
            mul_b = p_q;
        end
        prod     = 36'(mul_a) * 36'(mul_b);
        prod_mid = prod[33:16];
        cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        mu_reg_d  = mu_reg_q;
        x_d       = x_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        x_valid_d = 1'b0;
        // A tick that arrives mid-iteration is dropped but remembered
        overrun_d = overrun_q | (tick_q && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    if (bus.mu != mu_reg_q) begin
                        // New mu: restart the orbit, no iteration this tick
                        mu_reg_d = bus.mu;
                        x_d      = X0;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_MUL1;
                    end
                end
            end
            S_MUL1: begin
                p_d     = prod_mid;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                // Clamp to 1.0 if the result leaves the unit interval
                if ((|prod[35:34]) || (prod_mid > ONE)) begin
                    x_d = ONE;
                end else begin
                    x_d = prod_mid;
                end
                cnt_d     = cnt_inc;
                x_valid_d = (cnt_inc > BURN_LIM);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; RST aborts any iteration in progress immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= '0;
            tick_q    <= 1'b0;
            state_q   <= S_IDLE;
            mu_reg_q  <= '0;
            x_q       <= X0;
            p_q       <= '0;
            cnt_q     <= '0;
            x_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            mu_reg_q  <= mu_reg_d;
            x_q       <= x_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            x_valid_q <= x_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.iter_cnt = cnt_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_logistic_iter.sv
// Testbench for logistic_iter: two instances with different X0/BURN_IN,
// directed scenarios plus randomized ticks against a plain-arithmetic model.
module tb_logistic_iter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logistic_iter_if #(.CNT_W(16)) if0 ();
    logistic_iter_if #(.CNT_W(16)) if1 ();

    logistic_iter #(.X0(18'h08000), .BURN_IN(0), .CNT_W(16)) u0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0.slave)
    );

    logistic_iter #(.X0(18'h04CCD), .BURN_IN(2), .CNT_W(16)) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    logic [17:0] m_x   [2];
    logic [17:0] m_mu  [2];
    int          m_cnt [2];
    logic        m_ovr [2];

    function automatic logic [17:0] x0_of(input int sel);
        return (sel == 0) ? 18'h08000 : 18'h04CCD;
    endfunction

    function automatic int burn_of(input int sel);
        return (sel == 0) ? 0 : 2;
    endfunction

    // One map step with ordinary integer arithmetic
    function automatic logic [17:0] map_step(input logic [17:0] xv, input logic [17:0] muv);
        longint xl, oml, pl, rl, hi;
        xl  = longint'(xv);
        oml = 65536 - xl;
        pl  = ((xl * oml) >> 16) & 64'h3FFFF;
        rl  = longint'(muv) * pl;
        hi  = rl >> 16;
        if (hi > 65536) return 18'h10000;
        return hi[17:0];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_x[s]   = x0_of(s);
            m_mu[s]  = '0;
            m_cnt[s] = 0;
            m_ovr[s] = 1'b0;
        end
    endfunction

    // Expected effect of one accepted tick
    function automatic void model_tick(input int sel, input logic [17:0] mu,
                                       output int epulse, output int ebusy);
        if (mu != m_mu[sel]) begin
            m_mu[sel]  = mu;
            m_x[sel]   = x0_of(sel);
            m_cnt[sel] = 0;
            epulse     = 0;
            ebusy      = 0;
        end else begin
            m_x[sel]   = map_step(m_x[sel], mu);
            m_cnt[sel] = (m_cnt[sel] == 65535) ? 65535 : m_cnt[sel] + 1;
            epulse     = (m_cnt[sel] > burn_of(sel)) ? 1 : 0;
            ebusy      = 2;
        end
    endfunction

    task automatic set_cc(input int sel, input logic v);
        if (sel == 0) if0.calc_clock = v; else if1.calc_clock = v;
    endtask

    task automatic set_mu(input int sel, input logic [17:0] v);
        if (sel == 0) if0.mu = v; else if1.mu = v;
    endtask

    function automatic logic [17:0] get_x(input int sel);
        return (sel == 0) ? if0.x : if1.x;
    endfunction
    function automatic int get_cnt(input int sel);
        return (sel == 0) ? int'(if0.iter_cnt) : int'(if1.iter_cnt);
    endfunction
    function automatic logic get_valid(input int sel);
        return (sel == 0) ? if0.x_valid : if1.x_valid;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if0.busy : if1.busy;
    endfunction
    function automatic logic get_ovr(input int sel);
        return (sel == 0) ? if0.overrun : if1.overrun;
    endfunction

    // Drive one calc_clock pulse and observe the outcome over a fixed window
    task automatic do_tick(input int sel, input logic [17:0] mu,
                           output logic [17:0] ox, output int ocnt,
                           output int opulse, output int obusy);
        set_mu(sel, mu);
        @(negedge CLK);
        set_cc(sel, 1'b1);
        opulse = 0;
        obusy  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (get_valid(sel)) opulse++;
            if (get_busy(sel)) obusy++;
            if (i == 5) set_cc(sel, 1'b0);
        end
        ox   = get_x(sel);
        ocnt = get_cnt(sel);
        $display("tick inst%0d mu=%05h -> x=%05h cnt=%0d pulses=%0d busy=%0d ovr=%0b",
                 sel, mu, ox, ocnt, opulse, obusy, get_ovr(sel));
    endtask

    task automatic test_reset();
        logic [17:0] ox;
        int ocnt, op, ob, ep, eb;
        bit seen;
        RST = 1'b1;
        if0.calc_clock = 1'b0; if1.calc_clock = 1'b0;
        if0.mu = '0; if1.mu = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (if0.x !== 18'h08000 || if1.x !== 18'h04CCD || if0.x_valid !== 1'b0 ||
            if1.busy !== 1'b0 || if1.iter_cnt !== 16'd0 || if1.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: x0=%05h x1=%05h v=%b busy=%b cnt=%0d ovr=%b required 08000/04ccd/0/0/0/0",
                     if0.x, if1.x, if0.x_valid, if1.busy, if1.iter_cnt, if1.overrun);
        end
        RST = 1'b0;
        do_tick(1, 18'h18000, ox, ocnt, op, ob);
        model_tick(1, 18'h18000, ep, eb);
        // Start an iteration and hit RST during MUL1
        @(negedge CLK);
        if1.calc_clock = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (if1.busy) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_busy_timeout: busy got 0 required 1 within 20 cycles");
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if (if1.x !== 18'h04CCD || if1.x_valid !== 1'b0 || if1.busy !== 1'b0 ||
            if1.iter_cnt !== 16'd0 || if1.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul1: x=%05h v=%b busy=%b cnt=%0d ovr=%b required 04ccd/0/0/0/0",
                     if1.x, if1.x_valid, if1.busy, if1.iter_cnt, if1.overrun);
        end
        if1.calc_clock = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        op = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (if1.x_valid || if1.busy) op++;
        end
        checks++;
        if (if1.x !== 18'h04CCD || if1.iter_cnt !== 16'd0 || op != 0) begin
            errors++;
            $display("FAIL reset_quiet: x=%05h cnt=%0d activity=%0d required 04ccd/0/0",
                     if1.x, if1.iter_cnt, op);
        end
        $display("reset test done");
    endtask

    task automatic test_identity();
        logic [17:0] ox;
        int ocnt, op, ob, ep, eb;
        do_tick(0, 18'h20000, ox, ocnt, op, ob);
        model_tick(0, 18'h20000, ep, eb);
        checks++;
        if (ox !== 18'h08000 || ocnt != 0 || op != 0 || ob != 0) begin
            errors++;
            $display("FAIL identity_restart: x=%05h cnt=%0d pulses=%0d busy=%0d required 08000/0/0/0",
                     ox, ocnt, op, ob);
        end
        for (int k = 1; k <= 4; k++) begin
            do_tick(0, 18'h20000, ox, ocnt, op, ob);
            model_tick(0, 18'h20000, ep, eb);
            checks++;
            if (ox !== 18'h08000 || ocnt != k || op != 1 || ob != 2) begin
                errors++;
                $display("FAIL identity_iter%0d: x=%05h cnt=%0d pulses=%0d busy=%0d required 08000/%0d/1/2",
                         k, ox, ocnt, op, ob, k);
            end
        end
    endtask

    // Restart with mu, then three iterations with tabulated expected x
    task automatic test_sequence(input string name, input logic [17:0] mu,
                                 input logic [17:0] e1, input logic [17:0] e2,
                                 input logic [17:0] e3);
        logic [17:0] ox;
        logic [17:0] exp_tab [3];
        int ocnt, op, ob, ep, eb;
        exp_tab[0] = e1; exp_tab[1] = e2; exp_tab[2] = e3;
        do_tick(0, mu, ox, ocnt, op, ob);
        model_tick(0, mu, ep, eb);
        checks++;
        if (ox !== 18'h08000 || ocnt != 0 || op != 0) begin
            errors++;
            $display("FAIL %s_restart: x=%05h cnt=%0d pulses=%0d required 08000/0/0",
                     name, ox, ocnt, op);
        end
        for (int k = 0; k < 3; k++) begin
            do_tick(0, mu, ox, ocnt, op, ob);
            model_tick(0, mu, ep, eb);
            checks++;
            if (ox !== exp_tab[k] || ox !== m_x[0] || ocnt != k + 1 || op != 1) begin
                errors++;
                $display("FAIL %s_iter%0d: x=%05h cnt=%0d pulses=%0d required %05h/%0d/1",
                         name, k + 1, ox, ocnt, op, exp_tab[k], k + 1);
            end
        end
    endtask

    task automatic test_burn_in();
        logic [17:0] ox;
        int ocnt, op, ob, ep, eb;
        int exp_p [4];
        exp_p[0] = 0; exp_p[1] = 0; exp_p[2] = 1; exp_p[3] = 1;
        do_tick(1, 18'h30000, ox, ocnt, op, ob);
        model_tick(1, 18'h30000, ep, eb);
        for (int k = 0; k < 4; k++) begin
            do_tick(1, 18'h30000, ox, ocnt, op, ob);
            model_tick(1, 18'h30000, ep, eb);
            checks++;
            if (op != exp_p[k] || ox !== m_x[1] || ocnt != k + 1) begin
                errors++;
                $display("FAIL burn_in_iter%0d: pulses=%0d x=%05h cnt=%0d required %0d/%05h/%0d",
                         k + 1, op, ox, ocnt, exp_p[k], m_x[1], k + 1);
            end
        end
        do_tick(1, 18'h2C000, ox, ocnt, op, ob);
        model_tick(1, 18'h2C000, ep, eb);
        checks++;
        if (ox !== 18'h04CCD || ocnt != 0 || op != 0 || ob != 0) begin
            errors++;
            $display("FAIL burn_in_mu_change: x=%05h cnt=%0d pulses=%0d busy=%0d required 04ccd/0/0/0",
                     ox, ocnt, op, ob);
        end
    endtask

    task automatic test_overrun();
        logic [17:0] ox;
        int ocnt, op, ob, ep, eb, cnt_before;
        cnt_before = int'(if1.iter_cnt);
        if1.mu = 18'h2C000;
        // calc_clock 1,0,1 on consecutive cycles -> synchronized ticks 2 apart
        @(negedge CLK); if1.calc_clock = 1'b1;
        @(negedge CLK); if1.calc_clock = 1'b0;
        @(negedge CLK); if1.calc_clock = 1'b1;
        repeat (8) @(negedge CLK);
        if1.calc_clock = 1'b0;
        repeat (6) @(negedge CLK);
        model_tick(1, 18'h2C000, ep, eb);
        m_ovr[1] = 1'b1;
        $display("overrun burst inst1 -> x=%05h cnt=%0d ovr=%0b", if1.x, if1.iter_cnt, if1.overrun);
        checks++;
        if (if1.overrun !== 1'b1 || int'(if1.iter_cnt) != cnt_before + 1 || if1.x !== m_x[1]) begin
            errors++;
            $display("FAIL overrun_burst: ovr=%b cnt=%0d x=%05h required 1/%0d/%05h",
                     if1.overrun, if1.iter_cnt, if1.x, cnt_before + 1, m_x[1]);
        end
        do_tick(1, 18'h2C000, ox, ocnt, op, ob);
        model_tick(1, 18'h2C000, ep, eb);
        checks++;
        if (if1.overrun !== 1'b1 || ocnt != m_cnt[1] || ox !== m_x[1]) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%b cnt=%0d x=%05h required 1/%0d/%05h",
                     if1.overrun, ocnt, ox, m_cnt[1], m_x[1]);
        end
    endtask

    task automatic test_random();
        logic [17:0] ox, mu;
        int ocnt, op, ob, ep, eb, sel;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 1));
            mu  = m_mu[sel];
            if ($urandom_range(0, 4) == 0) mu = 18'($urandom());
            do_tick(sel, mu, ox, ocnt, op, ob);
            model_tick(sel, mu, ep, eb);
            checks++;
            if (ox !== m_x[sel] || ocnt != m_cnt[sel] || op != ep || ob != eb ||
                get_ovr(sel) !== m_ovr[sel]) begin
                errors++;
                $display("FAIL random_%0d inst%0d: x=%05h cnt=%0d pulses=%0d busy=%0d ovr=%b required %05h/%0d/%0d/%0d/%b",
                         n, sel, ox, ocnt, op, ob, get_ovr(sel),
                         m_x[sel], m_cnt[sel], ep, eb, m_ovr[sel]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sequence("sequence", 18'h10000, 18'h04000, 18'h03000, 18'h02700);
        test_sequence("edge_collapse", 18'h3FFFF, 18'h0FFFF, 18'h00000, 18'h00000);
        test_burn_in();
        test_overrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
